// File: rtl/router_pkg.sv
// router_pkg -- shared definitions for the 1x2 flit router.
//   DEFAULT_DATA_WIDTH / DEFAULT_FIFO_AW : default flit width and queue address width
//   DEST_BIT / PRIO_BIT                  : header bit positions for the default width
//   flit_t                               : flit type at the default width
//   dest_pos() / prio_pos()              : header bit positions for any width
package router_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_AW    = 2;

  // Header bits sit at the top of the flit: MSB routes, MSB-1 selects priority.
  localparam int DEST_BIT = DEFAULT_DATA_WIDTH - 1;
  localparam int PRIO_BIT = DEFAULT_DATA_WIDTH - 2;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] flit_t;

  function automatic int dest_pos(input int width);
    return width - 1;
  endfunction

  function automatic int prio_pos(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/router_1x2_port.sv
// router_1x2_port -- queueing and output stage for one router output port.
//   clk, rstn          : clock, async active-low reset
//   wr_i, data_i       : flit write into this port (already qualified by handshake)
//   prio_i             : selects the priority queue (only with ROUTER_1X2_PRIO_EN)
//   wr_ready_o         : the queue selected for data_i has room
//   data_o, valid_o    : output register
//   ready_i            : downstream ready
// Build option ROUTER_1X2_PRIO_EN adds a priority queue served ahead of the
// regular queue (strict, no aging); without it the port is a single FIFO.
module router_1x2_port
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_AW    = DEFAULT_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_i,
`ifdef ROUTER_1X2_PRIO_EN
  input  logic                  prio_i,
`endif
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  load;

  logic                  r_wr, r_rd, r_full, r_empty;
  logic [DATA_WIDTH-1:0] r_data;

  // Register is free when empty or when its current flit leaves this cycle.
  assign load = !valid_q || ready_i;

`ifdef ROUTER_1X2_PRIO_EN
  logic                  p_wr, p_rd, p_full, p_empty;
  logic [DATA_WIDTH-1:0] p_data;

  assign p_wr       = wr_i && prio_i;
  assign r_wr       = wr_i && !prio_i;
  assign wr_ready_o = prio_i ? !p_full : !r_full;

  router_fifo #(.DataWidth(DATA_WIDTH), .AddrWidth(FIFO_AW)) u_prio_q (
    .clk    (clk),
    .rstn   (rstn),
    .wr_i   (p_wr),
    .wdata_i(data_i),
    .rd_i   (p_rd),
    .rdata_o(p_data),
    .full_o (p_full),
    .empty_o(p_empty)
  );
`else
  assign r_wr       = wr_i;
  assign wr_ready_o = !r_full;
`endif

  router_fifo #(.DataWidth(DATA_WIDTH), .AddrWidth(FIFO_AW)) u_reg_q (
    .clk    (clk),
    .rstn   (rstn),
    .wr_i   (r_wr),
    .wdata_i(data_i),
    .rd_i   (r_rd),
    .rdata_o(r_data),
    .full_o (r_full),
    .empty_o(r_empty)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    r_rd    = 1'b0;
`ifdef ROUTER_1X2_PRIO_EN
    p_rd    = 1'b0;
`endif
    if (load) begin
`ifdef ROUTER_1X2_PRIO_EN
      if (!p_empty) begin
        p_rd    = 1'b1;
        data_d  = p_data;
        valid_d = 1'b1;
      end else
`endif
      if (!r_empty) begin
        r_rd    = 1'b1;
        data_d  = r_data;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/router_fifo.sv
// router_fifo -- synchronous FIFO with registered full/empty flags.
//   clk, rstn          : clock, async active-low reset
//   wr_i, wdata_i      : write request / data (ignored while full)
//   rd_i, rdata_o      : read request / head-of-queue data (ignored while empty)
//   full_o, empty_o    : registered occupancy flags
// Pointers carry one extra bit so that "empty" and "full" differ only in the MSB.
// Because the flags are registered, a full FIFO refuses a write even when it is
// being read in the same cycle.
module router_fifo #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 rd_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int                 Depth  = 1 << AddrWidth;
  localparam logic [AddrWidth:0] PtrOne = 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrWidth:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 do_wr, do_rd;

  assign do_wr = wr_i && !full_q;
  assign do_rd = rd_i && !empty_q;

  always_comb begin
    wptr_d  = do_wr ? wptr_q + PtrOne : wptr_q;
    rptr_d  = do_rd ? rptr_q + PtrOne : rptr_q;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AddrWidth-1:0] == rptr_d[AddrWidth-1:0]) &&
              (wptr_d[AddrWidth] != rptr_d[AddrWidth]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say it was written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AddrWidth-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AddrWidth-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/router_1x2.sv
// router_1x2 -- one input, two output flit router.
//   clk, rstn                    : clock, async active-low reset
//   Data_i, Valid_i, Ready_o     : inbound flit handshake
//   DataA_o, ValidA_o, ReadyA_i  : port A (destination bit 0)
//   DataB_o, ValidB_o, ReadyB_i  : port B (destination bit 1)
// Flit MSB selects the port; MSB-1 selects the priority queue when built with
// ROUTER_1X2_PRIO_EN. Flits pass through unmodified. A flit whose target queue
// is full holds the input (head-of-line), but each port drains independently.
module router_1x2
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_AW    = DEFAULT_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] Data_i,
  input  logic                  Valid_i,
  output logic                  Ready_o,
  output logic [DATA_WIDTH-1:0] DataA_o,
  output logic                  ValidA_o,
  input  logic                  ReadyA_i,
  output logic [DATA_WIDTH-1:0] DataB_o,
  output logic                  ValidB_o,
  input  logic                  ReadyB_i
);

  localparam int NUM_PORTS = 2;
  localparam int DestPos   = dest_pos(DATA_WIDTH);

  logic                                  dest;
  logic [NUM_PORTS-1:0]                  wr_rdy, vld, rdy;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  dout;

  assign dest    = Data_i[DestPos];
  // Ready depends only on the queue the current flit targets.
  assign Ready_o = wr_rdy[dest];
  assign rdy     = {ReadyB_i, ReadyA_i};

`ifdef ROUTER_1X2_PRIO_EN
  localparam int PrioPos = prio_pos(DATA_WIDTH);
  logic prio;
  assign prio = Data_i[PrioPos];
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    router_1x2_port #(.DATA_WIDTH(DATA_WIDTH), .FIFO_AW(FIFO_AW)) u_port (
      .clk       (clk),
      .rstn      (rstn),
      .wr_i      (Valid_i && Ready_o && (dest == 1'(p))),
`ifdef ROUTER_1X2_PRIO_EN
      .prio_i    (prio),
`endif
      .data_i    (Data_i),
      .wr_ready_o(wr_rdy[p]),
      .data_o    (dout[p]),
      .valid_o   (vld[p]),
      .ready_i   (rdy[p])
    );
  end

  assign DataA_o  = dout[0];
  assign ValidA_o = vld[0];
  assign DataB_o  = dout[1];
  assign ValidB_o = vld[1];

endmodule

// File: tb/tb_router_1x2.sv
// tb_router_1x2 -- directed self-checking bench for router_1x2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected orderings depend on ROUTER_1X2_PRIO_EN and follow the same macro.
module tb_router_1x2;
  import router_pkg::*;

  logic  clk = 1'b0;
  logic  rstn;
  flit_t Data_i;
  logic  Valid_i;
  logic  Ready_o;
  flit_t DataA_o, DataB_o;
  logic  ValidA_o, ValidB_o;
  logic  ReadyA_i, ReadyB_i;

  int n_cmp = 0;
  int n_err = 0;

  flit_t txq[$];
  flit_t gotA[$];
  flit_t gotB[$];

  router_1x2 dut (
    .clk     (clk),
    .rstn    (rstn),
    .Data_i  (Data_i),
    .Valid_i (Valid_i),
    .Ready_o (Ready_o),
    .DataA_o (DataA_o),
    .ValidA_o(ValidA_o),
    .ReadyA_i(ReadyA_i),
    .DataB_o (DataB_o),
    .ValidB_o(ValidB_o),
    .ReadyB_i(ReadyB_i)
  );

  always #5 clk = ~clk;

  // One cycle, falling edge to falling edge: log completed output handshakes,
  // present the head of txq and drop it if the router takes it.
  task automatic step();
    if (ValidA_o && ReadyA_i) gotA.push_back(DataA_o);
    if (ValidB_o && ReadyB_i) gotB.push_back(DataB_o);
    if (txq.size() > 0) begin
      Data_i  = txq[0];
      Valid_i = 1'b1;
      #1;
      if (Ready_o) void'(txq.pop_front());
    end else begin
      Data_i  = '0;
      Valid_i = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic clear_logs();
    txq.delete();
    gotA.delete();
    gotB.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; Data_i = '0; Valid_i = 1'b0; ReadyA_i = 1'b0; ReadyB_i = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ValidA_o !== 1'b0) begin n_err++; $display("FAIL rst_validA: got %b want 0", ValidA_o); end
    n_cmp++; if (ValidB_o !== 1'b0) begin n_err++; $display("FAIL rst_validB: got %b want 0", ValidB_o); end
    n_cmp++; if (DataA_o !== 32'h0) begin n_err++; $display("FAIL rst_dataA: got %h want 0", DataA_o); end
    n_cmp++; if (DataB_o !== 32'h0) begin n_err++; $display("FAIL rst_dataB: got %h want 0", DataB_o); end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (Ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", Ready_o); end
  endtask

  // Single A-bound flit: accepted at edge N, visible after edge N+1.
  task automatic test_latency();
    ReadyA_i = 1'b1;
    Data_i = 32'h0000_0001; Valid_i = 1'b1;
    #1;
    n_cmp++; if (Ready_o !== 1'b1) begin n_err++; $display("FAIL lat_ready: got %b want 1", Ready_o); end
    @(negedge clk);
    Valid_i = 1'b0; Data_i = '0;
    n_cmp++; if (ValidA_o !== 1'b0) begin n_err++; $display("FAIL lat_early: got %b want 0", ValidA_o); end
    @(negedge clk);
    n_cmp++; if (ValidA_o !== 1'b1) begin n_err++; $display("FAIL lat_validA: got %b want 1", ValidA_o); end
    n_cmp++; if (DataA_o !== 32'h0000_0001) begin n_err++; $display("FAIL lat_dataA: got %h want 00000001", DataA_o); end
    n_cmp++; if (ValidB_o !== 1'b0) begin n_err++; $display("FAIL lat_validB: got %b want 0", ValidB_o); end
    @(negedge clk);
    n_cmp++; if (ValidA_o !== 1'b0) begin n_err++; $display("FAIL lat_drop: got %b want 0", ValidA_o); end
  endtask

  // Four back-to-back flits must all leave within 2 + 4 cycles.
  task automatic test_back_to_back();
    flit_t exp[4] = '{32'h0000_0101, 32'h0000_0102, 32'h0000_0103, 32'h0000_0104};
    clear_logs();
    ReadyA_i = 1'b1;
    for (int i = 0; i < 4; i++) txq.push_back(exp[i]);
    repeat (6) step();
    n_cmp++; if (gotA.size() != 4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", gotA.size()); end
    for (int i = 0; i < 4 && i < gotA.size(); i++) begin
      n_cmp++; if (gotA[i] !== exp[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, gotA[i], exp[i]); end
    end
  endtask

  // The first flit occupies the stalled output register, so the next two
  // both sit in queues when the port is released.
  task automatic test_priority();
`ifdef ROUTER_1X2_PRIO_EN
    flit_t exp[3] = '{32'h0000_0005, 32'h4000_0020, 32'h0000_0010};
`else
    flit_t exp[3] = '{32'h0000_0005, 32'h0000_0010, 32'h4000_0020};
`endif
    clear_logs();
    ReadyA_i = 1'b0;
    txq.push_back(32'h0000_0005);
    txq.push_back(32'h0000_0010);
    txq.push_back(32'h4000_0020);
    repeat (5) step();
    n_cmp++; if (gotA.size() != 0) begin n_err++; $display("FAIL prio_hold: got %0d out want 0", gotA.size()); end
    n_cmp++; if (DataA_o !== 32'h0000_0005) begin n_err++; $display("FAIL prio_reg: got %h want 00000005", DataA_o); end
    ReadyA_i = 1'b1;
    repeat (6) step();
    n_cmp++; if (gotA.size() != 3) begin n_err++; $display("FAIL prio_count: got %0d want 3", gotA.size()); end
    for (int i = 0; i < 3 && i < gotA.size(); i++) begin
      n_cmp++; if (gotA[i] !== exp[i]) begin n_err++; $display("FAIL prio_order[%0d]: got %h want %h", i, gotA[i], exp[i]); end
    end
  endtask

  // B stalled: 1 flit in register + 4 queued, 6th blocks the input and the
  // A-bound flit behind it waits; releasing B drains everything in order.
  task automatic test_hol();
    flit_t expB[6] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003,
                       32'h8000_0004, 32'h8000_0005, 32'h8000_0006};
    clear_logs();
    ReadyA_i = 1'b1; ReadyB_i = 1'b0;
    for (int i = 0; i < 6; i++) txq.push_back(expB[i]);
    txq.push_back(32'h0000_00AA);
    repeat (10) step();
    n_cmp++; if (txq.size() != 2) begin n_err++; $display("FAIL hol_pending: got %0d want 2", txq.size()); end
    n_cmp++; if (Ready_o !== 1'b0) begin n_err++; $display("FAIL hol_ready: got %b want 0", Ready_o); end
    n_cmp++; if (ValidB_o !== 1'b1 || DataB_o !== expB[0]) begin n_err++; $display("FAIL hol_regB: got %b/%h want 1/%h", ValidB_o, DataB_o, expB[0]); end
    n_cmp++; if (ValidA_o !== 1'b0) begin n_err++; $display("FAIL hol_validA: got %b want 0", ValidA_o); end
    ReadyB_i = 1'b1;
    repeat (12) step();
    n_cmp++; if (gotB.size() != 6) begin n_err++; $display("FAIL hol_countB: got %0d want 6", gotB.size()); end
    for (int i = 0; i < 6 && i < gotB.size(); i++) begin
      n_cmp++; if (gotB[i] !== expB[i]) begin n_err++; $display("FAIL hol_orderB[%0d]: got %h want %h", i, gotB[i], expB[i]); end
    end
    n_cmp++; if (gotA.size() != 1) begin n_err++; $display("FAIL hol_countA: got %0d want 1", gotA.size()); end
    else begin
      n_cmp++; if (gotA[0] !== 32'h0000_00AA) begin n_err++; $display("FAIL hol_dataA: got %h want 000000aa", gotA[0]); end
    end
  endtask

  // A's regular queue full: priority flit still enters its own queue.
  task automatic test_prio_full();
`ifdef ROUTER_1X2_PRIO_EN
    localparam int N = 6;
    flit_t exp[N] = '{32'h0000_0031, 32'h4000_0003, 32'h0000_0032,
                      32'h0000_0033, 32'h0000_0034, 32'h0000_0035};
    logic exp_rdy = 1'b1;
`else
    localparam int N = 5;
    flit_t exp[N] = '{32'h0000_0031, 32'h0000_0032, 32'h0000_0033,
                      32'h0000_0034, 32'h0000_0035};
    logic exp_rdy = 1'b0;
`endif
    clear_logs();
    ReadyA_i = 1'b0; ReadyB_i = 1'b1;
    for (int i = 0; i < 5; i++) txq.push_back(32'h0000_0031 + 32'(i));
    repeat (7) step();
    n_cmp++; if (txq.size() != 0) begin n_err++; $display("FAIL pf_fill: got %0d pending want 0", txq.size()); end
    Data_i = 32'h0000_0036; Valid_i = 1'b1;
    #1;
    n_cmp++; if (Ready_o !== 1'b0) begin n_err++; $display("FAIL pf_reg_ready: got %b want 0", Ready_o); end
    Data_i = 32'h4000_0003;
    #1;
    n_cmp++; if (Ready_o !== exp_rdy) begin n_err++; $display("FAIL pf_prio_ready: got %b want %b", Ready_o, exp_rdy); end
`ifdef ROUTER_1X2_PRIO_EN
    @(negedge clk);
`endif
    Valid_i = 1'b0; Data_i = '0;
    ReadyA_i = 1'b1;
    repeat (9) step();
    n_cmp++; if (gotA.size() != N) begin n_err++; $display("FAIL pf_count: got %0d want %0d", gotA.size(), N); end
    for (int i = 0; i < N && i < gotA.size(); i++) begin
      n_cmp++; if (gotA[i] !== exp[i]) begin n_err++; $display("FAIL pf_order[%0d]: got %h want %h", i, gotA[i], exp[i]); end
    end
  endtask

  // Reset with flits in flight on both ports: nothing survives.
  task automatic test_reset_mid();
    clear_logs();
    ReadyA_i = 1'b0; ReadyB_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      txq.push_back(32'h0000_0051 + 32'(i));
      txq.push_back(32'h8000_0061 + 32'(i));
    end
    repeat (8) step();
    n_cmp++; if (ValidA_o !== 1'b1 || ValidB_o !== 1'b1) begin n_err++; $display("FAIL rm_pre: got %b%b want 11", ValidA_o, ValidB_o); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (ValidA_o !== 1'b0) begin n_err++; $display("FAIL rm_validA: got %b want 0", ValidA_o); end
    n_cmp++; if (ValidB_o !== 1'b0) begin n_err++; $display("FAIL rm_validB: got %b want 0", ValidB_o); end
    n_cmp++; if (DataA_o !== 32'h0 || DataB_o !== 32'h0) begin n_err++; $display("FAIL rm_data: got %h/%h want 0/0", DataA_o, DataB_o); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_logs();
    ReadyA_i = 1'b1; ReadyB_i = 1'b1;
    repeat (6) step();
    n_cmp++; if (gotA.size() != 0 || gotB.size() != 0) begin n_err++; $display("FAIL rm_stale: got %0d/%0d want 0/0", gotA.size(), gotB.size()); end
    n_cmp++; if (Ready_o !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", Ready_o); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_back_to_back();
    test_priority();
    test_hol();
    test_prio_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
